seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexes a 16-bit value onto a 4-digit common-anode 7-segment display through one shared
//   hex segment decoder. Sequences the digit index, drives the decoder's 4-bit number input and the
//   active-low anodes. Inserts a blanking gap between digits to prevent ghosting. Sits between
//   counter/datapath logic and the board display pins.
// PARAMETERS
//   SHOW_CYC   100000  clk cycles a digit's anode stays on per slot (1 ms at 100 MHz); legal range >= 1
//   BLANK_CYC  64      clk cycles all anodes off before each digit; legal range >= 2 (covers decoder latency)
// PORTS
//   clk         in   1   system clock, all logic on rising edge
//   rst         in   1   asynchronous, active-high reset
//   value       in   16  four hex nibbles; digit0 = value[3:0] ... digit3 = value[15:12]
//   digit_en    in   4   per-digit enable; 0 keeps that anode off for its whole slot
//   lz_blank    in   1   1 = suppress leading-zero digits
//   dp_in       in   4   per-digit decimal point request, 1 = lit
//   number      out  4   nibble to the shared segment decoder (registered, 1-cycle latency)
//   an          out  4   anodes, active low, one-hot-low or 4'b1111
//   dp          out  1   decimal point, active low
//   digit_idx   out  2   index of the current slot
//   frame_tick  out  1   1-cycle pulse on each 3->0 index wrap
// BEHAVIOUR
//   Reset values: an=4'b1111, dp=1, number=0, digit_idx=0, frame_tick=0, state=BLANK, slot counter=0,
//     shadow registers=0. Reset forces an/dp high immediately, without waiting for a clock edge,
//     including during SHOW.
//   FSM has two states.
//     BLANK: lasts BLANK_CYC cycles. an=4'b1111, dp=1. number = shadow nibble[digit_idx] from the
//       first BLANK cycle onward, so the decoder output settles before SHOW. After BLANK_CYC cycles
//       go to SHOW.
//     SHOW: lasts SHOW_CYC cycles. an[digit_idx]=0 if the digit is visible, else 4'b1111.
//       dp = ~shadow_dp[digit_idx] when visible, else 1. After SHOW_CYC cycles:
//       digit_idx <= digit_idx+1 (wraps 3->0), go to BLANK.
//   Slot counter: width $clog2(max(SHOW_CYC,BLANK_CYC)). It clears on every state change.
//   Slot length is exactly BLANK_CYC+SHOW_CYC cycles; frame length is 4x that.
//   Shadow capture: value, digit_en, lz_blank and dp_in are sampled together into shadow registers.
//     Sampling happens on the first clock after rst deasserts and on every edge that enters BLANK with
//     digit_idx=0. Input changes mid-frame never alter the frame in progress (no tearing).
//   frame_tick is high for the single cycle in which BLANK is entered with digit_idx=0,
//     except the first frame after reset.
//   Visibility: digit i is visible = shadow_en[i] AND NOT lz(i).
//     lz(i)=1 only if lz_blank=1, i>0, and nibbles i..3 are all zero.
//     Digit0 is never zero-blanked, so value 0 shows "0".
//     A dp request on a blanked digit is also suppressed.
//   All outputs are registered. an is never low for two digits in the same cycle.
//   After each index change, an is high for at least BLANK_CYC cycles.
// TESTING (SHOW_CYC=8, BLANK_CYC=2)
//   1 Release rst, value=16'h1234, digit_en=4'hF -> an=1111 for 2 cycles, then 1110 for 8 cycles;
//     the same pattern follows for 1101, 1011, 0111. number reads 4,3,2,1 in those slots.
//   2 lz_blank=1, value=16'h0050 -> an never 0111 or 1011; digits 1 ('5') and 0 ('0') shown.
//     value=16'h0000 -> only an=1110.
//   3 value 16'h1234->16'hABCD while digit 1 is shown -> digits 2,3 still show 2,1.
//     Next frame shows D,C,B,A.
//   4 digit_en=4'b0101, dp_in=4'b0010 -> an1/an3 never low; dp stays 1 (digit1 disabled);
//     slot timing unchanged (40-cycle frame).
//   5 Assert rst mid-SHOW of digit 2 -> an=1111 and dp=1 before the next edge. After release:
//     digit_idx=0, BLANK 2 cycles, then an=1110.
//   6 Free-run 5 frames -> frame_tick pulses exactly every 40 cycles, each pulse 1 cycle wide.
//     In every cycle an is one of 1111, 1110, 1101, 1011, 0111.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Scans a 16-bit value onto a 4-digit common-anode 7-segment display with a blanking gap
// between digits, feeding one shared hex decoder through the registered number output.
module seg_scan_ctrl #(
    parameter int SHOW_CYC  = 100000,
    parameter int BLANK_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic        lz_blank,
    input  logic [3:0]  dp_in,
    output logic [3:0]  number,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);
    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CYC);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [1:0]     idx_next;
    logic           first_reg;
    logic           capture;

    logic [15:0]    sh_value_reg, sh_value_next;
    logic [3:0]     sh_en_reg, sh_en_next;
    logic           sh_lz_reg, sh_lz_next;
    logic [3:0]     sh_dp_reg, sh_dp_next;

    logic [3:0]     nib_zero, lz, vis;
    logic [3:0]     an_next, number_next;
    logic           dp_next, frame_tick_next;

    // Slot sequencing: the wrap out of digit 3 is the only way BLANK is entered with index 0.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + 1'b1;
        idx_next        = digit_idx;
        frame_tick_next = 1'b0;
        case (state_reg)
            BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                end
            end
            SHOW: begin
                if (cnt_reg == SHOW_LAST) begin
                    state_next      = BLANK;
                    cnt_next        = '0;
                    idx_next        = digit_idx + 2'd1;
                    frame_tick_next = (digit_idx == 2'd3);
                end
            end
            default: begin
                state_next = BLANK;
                cnt_next   = '0;
            end
        endcase
    end

    // Inputs are latched only at frame boundaries so a frame never tears.
    always_comb begin
        capture       = first_reg | frame_tick_next;
        sh_value_next = capture ? value    : sh_value_reg;
        sh_en_next    = capture ? digit_en : sh_en_reg;
        sh_lz_next    = capture ? lz_blank : sh_lz_reg;
        sh_dp_next    = capture ? dp_in    : sh_dp_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign nib_zero[gi] = (sh_value_next[4*gi +: 4] == 4'h0);
            if (gi == 0) begin : g_lsd
                assign lz[gi] = 1'b0;
            end else begin : g_upper
                assign lz[gi] = sh_lz_next & (&nib_zero[3:gi]);
            end
            assign vis[gi] = sh_en_next[gi] & ~lz[gi];
        end
    endgenerate

    // Outputs are computed from next-state values so every port comes straight off a flop.
    always_comb begin
        number_next = sh_value_next[{idx_next, 2'b00} +: 4];
        an_next     = 4'hF;
        dp_next     = 1'b1;
        if (state_next == SHOW && vis[idx_next]) begin
            an_next[idx_next] = 1'b0;
            dp_next           = ~sh_dp_next[idx_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= BLANK;
            cnt_reg      <= '0;
            first_reg    <= 1'b1;
            digit_idx    <= 2'd0;
            sh_value_reg <= '0;
            sh_en_reg    <= '0;
            sh_lz_reg    <= 1'b0;
            sh_dp_reg    <= '0;
            number       <= 4'h0;
            an           <= 4'hF;
            dp           <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            first_reg    <= 1'b0;
            digit_idx    <= idx_next;
            sh_value_reg <= sh_value_next;
            sh_en_reg    <= sh_en_next;
            sh_lz_reg    <= sh_lz_next;
            sh_dp_reg    <= sh_dp_next;
            number       <= number_next;
            an           <= an_next;
            dp           <= dp_next;
            frame_tick   <= frame_tick_next;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with SHOW_CYC=8, BLANK_CYC=2 (10-cycle slots, 40-cycle frames).
module tb_seg_scan_ctrl;
    localparam int SC = 8;
    localparam int BC = 2;
    localparam int SLOT = SC + BC;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  number;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    seg_scan_ctrl #(.SHOW_CYC(SC), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .value(value), .digit_en(digit_en), .lz_blank(lz_blank),
        .dp_in(dp_in), .number(number), .an(an), .dp(dp), .digit_idx(digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic       dp;
        logic [3:0] num;
        logic [1:0] idx;
    } slot_t;

    slot_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int frame_no = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Drive the inputs for the next frame and queue what its four slots should show.
    task automatic load_frame(input logic [15:0] v, input logic [3:0] en, input logic lz,
                              input logic [3:0] dpi);
        slot_t s;
        bit    zero_above;
        value = v; digit_en = en; lz_blank = lz; dp_in = dpi;
        for (int k = 0; k < 4; k++) begin
            zero_above = 1'b1;
            for (int j = 3; j >= k; j--)
                if (v[4*j +: 4] != 4'h0) zero_above = 1'b0;
            s.num = v[4*k +: 4];
            s.idx = 2'(k);
            if (en[k] && !(lz && k > 0 && zero_above)) begin
                s.an = 4'hF & ~(4'b0001 << k);
                s.dp = ~dpi[k];
            end else begin
                s.an = 4'hF;
                s.dp = 1'b1;
            end
            exp_q.push_back(s);
        end
    endtask

    task automatic run_frame(input bit first, input int stop_at, input bit do_mid,
                             input logic [15:0] mid_val);
        slot_t cur;
        int k, o;
        cur = '0;
        for (int c = 0; c < stop_at; c++) begin
            @(negedge clk);
            k = c / SLOT;
            o = c % SLOT;
            check_val("frame_tick", frame_tick, (c == 0 && !first));
            check_val("an_legal", an inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}, 1);
            if (o < BC) begin
                check_val("blank_an", an, 4'hF);
                check_val("blank_dp", dp, 1);
                check_val("blank_idx", digit_idx, k);
            end else if (o == BC) begin
                check_val("sb_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    $display("frame %0d slot %0d: an=%b dp=%b number=%h idx=%0d",
                             frame_no, k, an, dp, number, digit_idx);
                    check_val("show_an", an, cur.an);
                    check_val("show_dp", dp, cur.dp);
                    check_val("show_number", number, cur.num);
                    check_val("show_idx", digit_idx, cur.idx);
                end
            end else begin
                check_val("hold_an", an, cur.an);
                check_val("hold_dp", dp, cur.dp);
                check_val("hold_number", number, cur.num);
            end
            if (do_mid && c == 15) value = mid_val;
        end
        frame_no++;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_an", an, 4'hF);
        check_val("rst_dp", dp, 1);
        check_val("rst_number", number, 0);
        check_val("rst_idx", digit_idx, 0);
        check_val("rst_tick", frame_tick, 0);

        // Basic scan order and number sequence
        load_frame(16'h1234, 4'hF, 1'b0, 4'h0);
        release_rst();
        run_frame(1, FRAME, 0, 16'h0);
        // Leading-zero blanking with a visible decimal point on digit 0
        load_frame(16'h0050, 4'hF, 1'b1, 4'h1);
        run_frame(0, FRAME, 0, 16'h0);
        load_frame(16'h0000, 4'hF, 1'b1, 4'h0);
        run_frame(0, FRAME, 0, 16'h0);
        // Mid-frame change must not tear; it lands on the following frame
        load_frame(16'h1234, 4'hF, 1'b0, 4'h0);
        run_frame(0, FRAME, 1, 16'hABCD);
        load_frame(16'hABCD, 4'hF, 1'b0, 4'h0);
        run_frame(0, FRAME, 0, 16'h0);
        // Disabled digits suppress anode and dp request
        load_frame(16'h1234, 4'b0101, 1'b0, 4'b0010);
        run_frame(0, FRAME, 0, 16'h0);
        // Asynchronous reset in the middle of digit 2's SHOW window
        load_frame(16'h1234, 4'hF, 1'b0, 4'h0);
        run_frame(0, 2 * SLOT + 4, 0, 16'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("async_rst_an", an, 4'hF);
        check_val("async_rst_dp", dp, 1);
        check_val("async_rst_idx", digit_idx, 0);
        exp_q.delete();
        // Free-run five frames with varied contents
        load_frame(16'h5A0F, 4'hF, 1'b0, 4'h8);
        release_rst();
        run_frame(1, FRAME, 0, 16'h0);
        load_frame(16'h00C0, 4'hF, 1'b1, 4'h4);
        run_frame(0, FRAME, 0, 16'h0);
        load_frame(16'h9876, 4'b1010, 1'b0, 4'hF);
        run_frame(0, FRAME, 0, 16'h0);
        load_frame(16'h000E, 4'hE, 1'b1, 4'h3);
        run_frame(0, FRAME, 0, 16'h0);
        load_frame(16'hF00D, 4'hF, 1'b1, 4'h0);
        run_frame(0, FRAME, 0, 16'h0);
        check_val("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
